// File: rtl/prog_run_pkg.sv
// prog_run_pkg: shared state encoding, status codes and default parameters for the run sequencer.
package prog_run_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_RD_ADDR,
        S_RD_CAP,
        S_RES_OUT,
        S_REPORT
    } run_state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_OK      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [7:0] DEF_LOAD_BASE    = 8'd0;
    localparam int         DEF_LOAD_LEN     = 4;
    localparam logic [7:0] DEF_RES_BASE     = 8'd8;
    localparam int         DEF_RES_LEN      = 4;
    localparam int         DEF_START_CYCLES = 2;
    localparam int         DEF_TIMEOUT      = 1000;
    localparam int         DEF_CW           = 10;
endpackage

// File: rtl/run_cycle_ctr.sv
// run_cycle_ctr: saturating cycle counter with clear/enable and a reached-timeout flag.
module run_cycle_ctr import prog_run_pkg::*; #(
    parameter int CW      = DEF_CW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          at_timeout
);
    always_ff @(posedge clk)
        if (reset || clr) count <= '0;
        else if (en && count != '1) count <= count + CW'(1);
    assign at_timeout = count >= CW'(TIMEOUT);
endmodule

// File: rtl/prog_run_seq.sv
// prog_run_seq: loads operands into core data memory, starts the core, times the run and streams results back.
module prog_run_seq import prog_run_pkg::*; #(
    parameter logic [7:0] LOAD_BASE    = DEF_LOAD_BASE,
    parameter int         LOAD_LEN     = DEF_LOAD_LEN,
    parameter logic [7:0] RES_BASE     = DEF_RES_BASE,
    parameter int         RES_LEN      = DEF_RES_LEN,
    parameter int         START_CYCLES = DEF_START_CYCLES,
    parameter int         TIMEOUT      = DEF_TIMEOUT,
    parameter int         CW           = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          res_valid,
    output logic [7:0]    res_data,
    output logic          res_last,
    input  logic          res_ready,
    output logic          core_start,
    input  logic          core_done,
    output logic          mem_own,
    output logic [7:0]    mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic [CW-1:0] run_cycles,
    output logic [1:0]    status,
    output logic          status_valid
);
    localparam int IW = 16;
    run_state_t    state;
    logic [IW-1:0] idx;
    logic [CW-1:0] count;
    logic          at_timeout, start_last, rd_phase;
    assign start_last = idx == IW'(START_CYCLES - 1);
    // Counting begins on the last START cycle so the first RUN cycle already reads 1.
    run_cycle_ctr #(.CW(CW), .TIMEOUT(TIMEOUT)) u_ctr (
        .clk(clk),
        .reset(reset),
        .clr(state == S_IDLE),
        .en(state == S_RUN || (state == S_START && start_last)),
        .count(count),
        .at_timeout(at_timeout)
    );
    assign cmd_ready    = state == S_IDLE;
    assign ld_ready     = state == S_LOAD;
    assign core_start   = state == S_START && !reset;
    assign mem_we       = ld_ready && ld_valid && !reset;
    assign mem_wdata    = mem_we ? ld_data : 8'd0;
    assign rd_phase     = state == S_RD_ADDR || state == S_RD_CAP || state == S_RES_OUT;
    assign mem_own      = ld_ready || rd_phase;
    assign mem_addr     = ld_ready ? LOAD_BASE + idx[7:0] : rd_phase ? RES_BASE + idx[7:0] : 8'd0;
    assign res_valid    = state == S_RES_OUT;
    assign res_last     = res_valid && idx == IW'(RES_LEN - 1);
    assign status_valid = state == S_REPORT;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            res_data   <= '0;
            run_cycles <= '0;
            status     <= ST_NONE;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    state      <= S_LOAD;
                    idx        <= '0;
                    run_cycles <= '0;
                    status     <= ST_NONE;
                end
                S_LOAD: if (ld_valid) begin
                    idx   <= idx == IW'(LOAD_LEN - 1) ? '0 : idx + IW'(1);
                    state <= idx == IW'(LOAD_LEN - 1) ? S_START : S_LOAD;
                end
                S_START: begin
                    idx   <= start_last ? '0 : idx + IW'(1);
                    state <= start_last ? S_RUN : S_START;
                end
                // A done seen while the counter still reads 1 is stale from a previous run.
                S_RUN: if (core_done && count != CW'(1)) begin
                    run_cycles <= count;
                    status     <= ST_OK;
                    state      <= S_RD_ADDR;
                end else if (at_timeout) begin
                    run_cycles <= CW'(TIMEOUT);
                    status     <= ST_TIMEOUT;
                    state      <= S_REPORT;
                end
                S_RD_ADDR: state <= S_RD_CAP;
                S_RD_CAP: begin
                    res_data <= mem_rdata;
                    state    <= S_RES_OUT;
                end
                S_RES_OUT: if (res_ready) begin
                    idx   <= idx + IW'(1);
                    state <= res_last ? S_REPORT : S_RD_ADDR;
                end
                S_REPORT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule
